// File: rtl/memory_bus_arbiter_pkg.sv
// Shared definitions for the CPU/DMA memory bus arbiter and its integration:
// FSM state encoding, requester identities and the halt counter width.
package memory_bus_arbiter_pkg;

   localparam int unsigned HALT_CNT_W = 12;

   localparam logic REQ_CPU = 1'b0;
   localparam logic REQ_DMA = 1'b1;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_ACCESS   = 2'd1,
      ST_COMPLETE = 2'd2
   } arb_state_t;

   function automatic logic other_requester(input logic id);
      return (id == REQ_CPU) ? REQ_DMA : REQ_CPU;
   endfunction

endpackage

// File: rtl/memory_bus_arbiter_halt_timer.sv
// Halt watchdog: counts stalled access cycles and flags when the next stalled
// cycle would reach the configured limit.
module memory_bus_arbiter_halt_timer #(
   parameter int unsigned HALT_TIMEOUT = 4095
) (
   input  logic clk,
   input  logic reset,
   input  logic clear,
   input  logic count,
   output logic expired
);
   import memory_bus_arbiter_pkg::*;

   localparam logic [HALT_CNT_W-1:0] LAST_COUNT = HALT_CNT_W'(HALT_TIMEOUT - 32'd1);
   localparam logic [HALT_CNT_W-1:0] CNT_ONE    = HALT_CNT_W'(32'd1);
   localparam logic [HALT_CNT_W-1:0] CNT_ZERO   = HALT_CNT_W'(32'd0);

   logic [HALT_CNT_W-1:0] count_r;

   // Stalled-cycle counter; forced to zero whenever no access is in flight.
   always_ff @(posedge clk) begin
      if (!reset) begin
         count_r <= CNT_ZERO;
      end else if (clear) begin
         count_r <= CNT_ZERO;
      end else if (count && !expired) begin
         count_r <= count_r + CNT_ONE;
      end else begin
         count_r <= count_r;
      end
   end

   // The stalled cycle that sees this high is the HALT_TIMEOUT-th one.
   assign expired = (count_r >= LAST_COUNT);

endmodule

// File: rtl/memory_bus_arbiter.sv
// Round-robin arbiter granting single CPU or DMA accesses onto a stallable
// memory bus, with a sticky abort flag for accesses stuck on halt.
module memory_bus_arbiter #(
   parameter int unsigned HALT_TIMEOUT = 4095
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        cpu_request,
   input  logic        dma_request,
   input  logic [23:0] cpu_address,
   input  logic [23:0] dma_address,
   input  logic [7:0]  cpu_data_in,
   input  logic [7:0]  dma_data_in,
   input  logic        cpu_write_enable,
   input  logic        dma_write_enable,
   output logic [7:0]  cpu_data_out,
   output logic [7:0]  dma_data_out,
   output logic        cpu_done,
   output logic        dma_done,
   output logic        grant,
   output logic [23:0] mem_address,
   output logic [7:0]  mem_data_out,
   output logic        mem_bus_enable,
   output logic        mem_write_enable,
   input  logic [7:0]  mem_data_in,
   input  logic        mem_bus_halt,
   output logic        timeout_error
);
   import memory_bus_arbiter_pkg::*;

   arb_state_t state_r;
   logic       rr_prio_r;
   logic       owner_s;
   logic       clear_s;
   logic       count_s;
   logic       expired_s;

   // Tie goes to whoever was not granted last; a lone request always wins.
   always_comb begin
      owner_s = REQ_CPU;
      if (cpu_request && dma_request) begin
         owner_s = rr_prio_r;
      end else if (dma_request) begin
         owner_s = REQ_DMA;
      end else begin
         owner_s = REQ_CPU;
      end
   end

   assign clear_s = (state_r != ST_ACCESS);
   assign count_s = (state_r == ST_ACCESS) && mem_bus_halt;

   memory_bus_arbiter_halt_timer #(
      .HALT_TIMEOUT (HALT_TIMEOUT)
   ) halt_timer (
      .clk     (clk),
      .reset   (reset),
      .clear   (clear_s),
      .count   (count_s),
      .expired (expired_s)
   );

   // Arbitration FSM; every bus and requester output is registered here.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_r          <= ST_IDLE;
         rr_prio_r        <= REQ_CPU;
         grant            <= REQ_CPU;
         mem_address      <= 24'h000000;
         mem_data_out     <= 8'h00;
         mem_bus_enable   <= 1'b0;
         mem_write_enable <= 1'b0;
         cpu_data_out     <= 8'h00;
         dma_data_out     <= 8'h00;
         cpu_done         <= 1'b0;
         dma_done         <= 1'b0;
         timeout_error    <= 1'b0;
      end else begin
         cpu_done <= 1'b0;
         dma_done <= 1'b0;
         case (state_r)
            ST_IDLE: begin
               if (cpu_request || dma_request) begin
                  grant            <= owner_s;
                  rr_prio_r        <= other_requester(owner_s);
                  mem_address      <= (owner_s == REQ_DMA) ? dma_address : cpu_address;
                  mem_data_out     <= (owner_s == REQ_DMA) ? dma_data_in : cpu_data_in;
                  mem_write_enable <= (owner_s == REQ_DMA) ? dma_write_enable : cpu_write_enable;
                  mem_bus_enable   <= 1'b1;
                  state_r          <= ST_ACCESS;
               end
            end
            ST_ACCESS: begin
               if (!mem_bus_halt || expired_s) begin
                  // A timed-out abort leaves read data untouched.
                  if (mem_bus_halt) begin
                     timeout_error <= 1'b1;
                  end else if (!mem_write_enable) begin
                     if (grant == REQ_DMA) begin
                        dma_data_out <= mem_data_in;
                     end else begin
                        cpu_data_out <= mem_data_in;
                     end
                  end
                  if (grant == REQ_DMA) begin
                     dma_done <= 1'b1;
                  end else begin
                     cpu_done <= 1'b1;
                  end
                  mem_bus_enable   <= 1'b0;
                  mem_write_enable <= 1'b0;
                  state_r          <= ST_COMPLETE;
               end
            end
            ST_COMPLETE: begin
               state_r <= ST_IDLE;
            end
            default: begin
               mem_bus_enable   <= 1'b0;
               mem_write_enable <= 1'b0;
               state_r          <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_memory_bus_arbiter.sv
// Self-checking bench for memory_bus_arbiter: directed vector table, halt and
// reset sequences, and randomized traffic against a behavioural model.
module tb_memory_bus_arbiter;

   localparam int unsigned M_TIMEOUT = 4095;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        cpu_request = 1'b0, dma_request = 1'b0;
   logic [23:0] cpu_address = 24'h0, dma_address = 24'h0;
   logic [7:0]  cpu_data_in = 8'h0, dma_data_in = 8'h0;
   logic        cpu_write_enable = 1'b0, dma_write_enable = 1'b0;
   logic [7:0]  mem_data_in = 8'h0;
   logic        mem_bus_halt = 1'b0;

   logic [7:0]  cpu_data_out, dma_data_out;
   logic        cpu_done, dma_done, grant;
   logic [23:0] mem_address;
   logic [7:0]  mem_data_out;
   logic        mem_bus_enable, mem_write_enable, timeout_error;

   logic [7:0]  cpu_data_out_t, dma_data_out_t;
   logic        cpu_done_t, dma_done_t, grant_t;
   logic [23:0] mem_address_t;
   logic [7:0]  mem_data_out_t;
   logic        mem_bus_enable_t, mem_write_enable_t, timeout_error_t;

   memory_bus_arbiter dut (
      .clk(clk), .reset(reset),
      .cpu_request(cpu_request), .dma_request(dma_request),
      .cpu_address(cpu_address), .dma_address(dma_address),
      .cpu_data_in(cpu_data_in), .dma_data_in(dma_data_in),
      .cpu_write_enable(cpu_write_enable), .dma_write_enable(dma_write_enable),
      .cpu_data_out(cpu_data_out), .dma_data_out(dma_data_out),
      .cpu_done(cpu_done), .dma_done(dma_done), .grant(grant),
      .mem_address(mem_address), .mem_data_out(mem_data_out),
      .mem_bus_enable(mem_bus_enable), .mem_write_enable(mem_write_enable),
      .mem_data_in(mem_data_in), .mem_bus_halt(mem_bus_halt),
      .timeout_error(timeout_error)
   );

   memory_bus_arbiter #(.HALT_TIMEOUT(8)) dut_short (
      .clk(clk), .reset(reset),
      .cpu_request(cpu_request), .dma_request(dma_request),
      .cpu_address(cpu_address), .dma_address(dma_address),
      .cpu_data_in(cpu_data_in), .dma_data_in(dma_data_in),
      .cpu_write_enable(cpu_write_enable), .dma_write_enable(dma_write_enable),
      .cpu_data_out(cpu_data_out_t), .dma_data_out(dma_data_out_t),
      .cpu_done(cpu_done_t), .dma_done(dma_done_t), .grant(grant_t),
      .mem_address(mem_address_t), .mem_data_out(mem_data_out_t),
      .mem_bus_enable(mem_bus_enable_t), .mem_write_enable(mem_write_enable_t),
      .mem_data_in(mem_data_in), .mem_bus_halt(mem_bus_halt),
      .timeout_error(timeout_error_t)
   );

   always #5 clk = ~clk;

   logic [53:0] act_v;
   assign act_v = {mem_bus_enable, mem_write_enable, grant, cpu_done, dma_done, timeout_error,
                   mem_address, mem_data_out, cpu_data_out, dma_data_out};

   int errors = 0;
   int checks = 0;

   // Behavioural model: which phase of a transaction we are in, who owns it.
   int          m_phase = 0;
   int          m_halts = 0;
   logic        m_prio = 1'b0, m_grant = 1'b0;
   logic        m_en = 1'b0, m_we = 1'b0, m_cdone = 1'b0, m_ddone = 1'b0, m_to = 1'b0;
   logic [23:0] m_addr = 24'h0;
   logic [7:0]  m_dout = 8'h0, m_cdata = 8'h0, m_ddata = 8'h0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic model_step();
      if (!reset) begin
         m_phase = 0; m_halts = 0; m_prio = 1'b0; m_grant = 1'b0;
         m_en = 1'b0; m_we = 1'b0; m_cdone = 1'b0; m_ddone = 1'b0; m_to = 1'b0;
         m_addr = 24'h0; m_dout = 8'h0; m_cdata = 8'h0; m_ddata = 8'h0;
      end else begin
         case (m_phase)
            0: begin
               if (cpu_request || dma_request) begin
                  m_grant = (cpu_request && dma_request) ? m_prio : dma_request;
                  m_prio  = !m_grant;
                  m_addr  = m_grant ? dma_address : cpu_address;
                  m_dout  = m_grant ? dma_data_in : cpu_data_in;
                  m_we    = m_grant ? dma_write_enable : cpu_write_enable;
                  m_en    = 1'b1;
                  m_halts = 0;
                  m_phase = 1;
               end
            end
            1: begin
               if (mem_bus_halt) m_halts++;
               if (!mem_bus_halt || m_halts >= int'(M_TIMEOUT)) begin
                  if (mem_bus_halt) m_to = 1'b1;
                  else if (!m_we) begin
                     if (m_grant) m_ddata = mem_data_in;
                     else m_cdata = mem_data_in;
                  end
                  if (m_grant) m_ddone = 1'b1;
                  else m_cdone = 1'b1;
                  m_en = 1'b0; m_we = 1'b0;
                  m_phase = 2;
               end
            end
            default: begin
               m_cdone = 1'b0; m_ddone = 1'b0;
               m_phase = 0;
            end
         endcase
      end
   endtask

   task automatic step();
      @(posedge clk);
      model_step();
      #1;
      check($sformatf("model t=%0t", $time), act_v,
            {m_en, m_we, m_grant, m_cdone, m_ddone, m_to, m_addr, m_dout, m_cdata, m_ddata});
   endtask

   task automatic do_reset();
      cpu_request = 1'b0; dma_request = 1'b0; mem_bus_halt = 1'b0;
      reset = 1'b0;
      step();
      step();
      reset = 1'b1;
   endtask

   typedef struct {
      logic        creq, dreq, cwe, dwe, halt;
      logic [23:0] caddr, daddr;
      logic [7:0]  cdin, ddin, mdin;
      logic        en, we, gnt, cdone, ddone;
      logic [23:0] addr;
      logic [7:0]  mdout, cdata, ddata;
   } vec_t;

   localparam int NVEC = 15;
   vec_t vecs [NVEC];

   initial begin
      int acc;
      int n;

      vecs[0]  = '{1'b1,1'b1,1'b1,1'b0,1'b0, 24'h008001,24'h010000, 8'h33,8'h77,8'hC3, 1'b1,1'b1,1'b0,1'b0,1'b0, 24'h008001,8'h33,8'h00,8'h00};
      vecs[1]  = '{1'b1,1'b1,1'b1,1'b0,1'b0, 24'h008001,24'h010000, 8'h33,8'h77,8'hC3, 1'b0,1'b0,1'b0,1'b1,1'b0, 24'h008001,8'h33,8'h00,8'h00};
      vecs[2]  = '{1'b1,1'b1,1'b1,1'b0,1'b0, 24'h008001,24'h010000, 8'h33,8'h77,8'hC3, 1'b0,1'b0,1'b0,1'b0,1'b0, 24'h008001,8'h33,8'h00,8'h00};
      vecs[3]  = '{1'b1,1'b1,1'b1,1'b0,1'b0, 24'h008001,24'h010000, 8'h33,8'h77,8'hC3, 1'b1,1'b0,1'b1,1'b0,1'b0, 24'h010000,8'h77,8'h00,8'h00};
      vecs[4]  = '{1'b1,1'b1,1'b1,1'b0,1'b0, 24'h008001,24'h010000, 8'h33,8'h77,8'hC3, 1'b0,1'b0,1'b1,1'b0,1'b1, 24'h010000,8'h77,8'h00,8'hC3};
      vecs[5]  = '{1'b1,1'b1,1'b1,1'b0,1'b0, 24'h008001,24'h010000, 8'h33,8'h77,8'hC3, 1'b0,1'b0,1'b1,1'b0,1'b0, 24'h010000,8'h77,8'h00,8'hC3};
      vecs[6]  = '{1'b1,1'b1,1'b1,1'b0,1'b0, 24'h008001,24'h010000, 8'h33,8'h77,8'hC3, 1'b1,1'b1,1'b0,1'b0,1'b0, 24'h008001,8'h33,8'h00,8'hC3};
      vecs[7]  = '{1'b1,1'b1,1'b1,1'b0,1'b0, 24'h008001,24'h010000, 8'h33,8'h77,8'hC3, 1'b0,1'b0,1'b0,1'b1,1'b0, 24'h008001,8'h33,8'h00,8'hC3};
      vecs[8]  = '{1'b0,1'b0,1'b1,1'b0,1'b0, 24'h008001,24'h010000, 8'h33,8'h77,8'hC3, 1'b0,1'b0,1'b0,1'b0,1'b0, 24'h008001,8'h33,8'h00,8'hC3};
      vecs[9]  = '{1'b1,1'b0,1'b0,1'b0,1'b0, 24'h000010,24'h010000, 8'h00,8'h77,8'h5A, 1'b1,1'b0,1'b0,1'b0,1'b0, 24'h000010,8'h00,8'h00,8'hC3};
      vecs[10] = '{1'b0,1'b0,1'b0,1'b0,1'b0, 24'h000010,24'h010000, 8'h00,8'h77,8'h5A, 1'b0,1'b0,1'b0,1'b1,1'b0, 24'h000010,8'h00,8'h5A,8'hC3};
      vecs[11] = '{1'b0,1'b0,1'b0,1'b0,1'b0, 24'h000010,24'h010000, 8'h00,8'h77,8'h5A, 1'b0,1'b0,1'b0,1'b0,1'b0, 24'h000010,8'h00,8'h5A,8'hC3};
      vecs[12] = '{1'b0,1'b1,1'b0,1'b1,1'b0, 24'h000010,24'h0000FF, 8'h00,8'h11,8'h5A, 1'b1,1'b1,1'b1,1'b0,1'b0, 24'h0000FF,8'h11,8'h5A,8'hC3};
      vecs[13] = '{1'b0,1'b0,1'b0,1'b1,1'b0, 24'h000010,24'h0000FF, 8'h00,8'h11,8'h5A, 1'b0,1'b0,1'b1,1'b0,1'b1, 24'h0000FF,8'h11,8'h5A,8'hC3};
      vecs[14] = '{1'b0,1'b0,1'b0,1'b1,1'b0, 24'h000010,24'h0000FF, 8'h00,8'h11,8'h5A, 1'b0,1'b0,1'b1,1'b0,1'b0, 24'h0000FF,8'h11,8'h5A,8'hC3};

      do_reset();
      check("reset_state", act_v, 64'd0);

      // Directed vectors: tie round-robin, write/read, dropped request.
      for (int i = 0; i < NVEC; i++) begin
         cpu_request = vecs[i].creq; dma_request = vecs[i].dreq;
         cpu_write_enable = vecs[i].cwe; dma_write_enable = vecs[i].dwe;
         mem_bus_halt = vecs[i].halt;
         cpu_address = vecs[i].caddr; dma_address = vecs[i].daddr;
         cpu_data_in = vecs[i].cdin; dma_data_in = vecs[i].ddin;
         mem_data_in = vecs[i].mdin;
         step();
         check($sformatf("vec%0d", i), act_v,
               {vecs[i].en, vecs[i].we, vecs[i].gnt, vecs[i].cdone, vecs[i].ddone, 1'b0,
                vecs[i].addr, vecs[i].mdout, vecs[i].cdata, vecs[i].ddata});
      end

      // Long halt below the default limit.
      do_reset();
      dma_request = 1'b1; dma_write_enable = 1'b0; dma_address = 24'h020000;
      mem_bus_halt = 1'b1;
      step();
      acc = mem_bus_enable ? 1 : 0;
      for (int i = 0; i < 50; i++) begin
         step();
         if (mem_bus_enable) acc++;
      end
      mem_bus_halt = 1'b0; dma_request = 1'b0; mem_data_in = 8'hA5;
      step();
      check("halt50_access_cycles", acc, 64'd51);
      check("halt50_dma_done", dma_done, 64'd1);
      check("halt50_dma_data", dma_data_out, 64'hA5);
      check("halt50_timeout", timeout_error, 64'd0);

      // Stuck halt on the short-timeout instance.
      do_reset();
      dma_request = 1'b1; dma_address = 24'h000123; mem_data_in = 8'h3C;
      step();
      dma_request = 1'b0;
      step();
      step();
      check("short_prior_read", dma_data_out_t, 64'h3C);
      dma_request = 1'b1; mem_bus_halt = 1'b1; mem_data_in = 8'hEE;
      step();
      dma_request = 1'b0;
      acc = 0;
      n = 0;
      while (mem_bus_enable_t && n < 40) begin
         acc++;
         n++;
         step();
      end
      check("timeout_access_cycles", acc, 64'd8);
      check("timeout_dma_done", dma_done_t, 64'd1);
      check("timeout_flag", timeout_error_t, 64'd1);
      check("timeout_data_kept", dma_data_out_t, 64'h3C);
      mem_bus_halt = 1'b0;
      step();
      check("timeout_done_once", dma_done_t, 64'd0);
      check("timeout_sticky", timeout_error_t, 64'd1);
      do_reset();
      check("timeout_cleared", timeout_error_t, 64'd0);

      // Reset in the middle of an access.
      cpu_request = 1'b1; cpu_address = 24'h00ABCD; mem_bus_halt = 1'b1;
      step();
      check("midreset_in_access", mem_bus_enable, 64'd1);
      reset = 1'b0; cpu_request = 1'b0;
      step();
      check("midreset_outputs", act_v, 64'd0);
      reset = 1'b1; mem_bus_halt = 1'b0;
      step();
      check("midreset_no_done", act_v, 64'd0);

      // Randomized traffic against the model.
      for (int i = 0; i < 800; i++) begin
         reset = ($urandom_range(99) != 0);
         cpu_request = $urandom_range(1);
         dma_request = $urandom_range(1);
         cpu_write_enable = $urandom_range(1);
         dma_write_enable = $urandom_range(1);
         cpu_address = 24'($urandom);
         dma_address = 24'($urandom);
         cpu_data_in = 8'($urandom);
         dma_data_in = 8'($urandom);
         mem_data_in = 8'($urandom);
         mem_bus_halt = ($urandom_range(9) < 3);
         step();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/memory_bus_arbiter.md
MEMORY_BUS_ARBITER -- requirements
Module: memory_bus_arbiter

Interface
REQ-001 SHALL have parameter HALT_TIMEOUT, 4095, max cycles an access may sit halted before abort.
REQ-002 SHALL have port clk  input  1  single system clock; all logic on rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-low reset.
REQ-004 SHALL have ports cpu_request / dma_request  input  1  each requester asks for one bus access.
REQ-005 SHALL have ports cpu_address / dma_address  input  24  access address.
REQ-006 SHALL have ports cpu_data_in / dma_data_in  input  8  write data.
REQ-007 SHALL have ports cpu_write_enable / dma_write_enable  input  1  1=write, 0=read.
REQ-008 SHALL have ports cpu_data_out / dma_data_out  output  8  registered read data.
REQ-009 SHALL have ports cpu_done / dma_done  output  1  one-cycle completion pulse.
REQ-010 SHALL have port grant  output  1  owner of current/last access (0=cpu, 1=dma).
REQ-011 SHALL have ports mem_address  output  24; mem_data_out  output  8; mem_bus_enable  output  1; mem_write_enable  output  1  drive the memory bus.
REQ-012 SHALL have ports mem_data_in  input  8  read data from bus; mem_bus_halt  input  1  bus stall.
REQ-013 SHALL have port timeout_error  output  1  sticky flag, access aborted on halt timeout.

Function
REQ-014 SHALL implement FSM states IDLE, ACCESS, COMPLETE.
REQ-015 IDLE: on any request sampled high, SHALL select owner, latch its address/data/write_enable into mem_* registers, set grant, go ACCESS next edge.
REQ-016 Both requests high in IDLE: SHALL grant the requester not granted last (round-robin); after reset cpu wins first tie.
REQ-017 ACCESS: SHALL assert mem_bus_enable=1 and mem_write_enable=latched value; mem_address/mem_data_out stable for whole access.
REQ-018 ACCESS with mem_bus_halt=1: SHALL stay in ACCESS, increment 12-bit halt counter.
REQ-019 ACCESS with mem_bus_halt=0: SHALL capture mem_data_in into owner's data_out (reads only; writes leave data_out unchanged), go COMPLETE.
REQ-020 COMPLETE: SHALL pulse owner's done for exactly one cycle, deassert mem_bus_enable and mem_write_enable, return to IDLE.
REQ-021 Unhalted latency: request sampled at edge n -> ACCESS n+1 -> done high during cycle after n+2 edge; max throughput one access per 3 cycles.
REQ-022 Halt counter reaching HALT_TIMEOUT in ACCESS: SHALL abort to COMPLETE, set timeout_error, pulse done, data_out unchanged.
REQ-023 timeout_error SHALL clear only on reset.
REQ-024 Request dropped during ACCESS: SHALL complete access normally and still pulse done.
REQ-025 Requester SHALL see at most one done per grant; request held high after done SHALL start a new access from IDLE subject to round-robin.
REQ-026 mem_bus_enable and mem_write_enable SHALL never be high outside ACCESS.
REQ-027 Halt counter SHALL clear on every entry to ACCESS.

Reset
REQ-028 reset low at a rising edge SHALL force IDLE, mem_bus_enable=0, mem_write_enable=0, mem_address=0, mem_data_out=0, cpu/dma_data_out=0, done=0, grant=0, timeout_error=0, halt counter=0, round-robin pointer to cpu.
REQ-029 Reset mid-ACCESS SHALL abort access with no done pulse; bus enable drops at that same edge.

Structure
REQ-030 FSM state encodings and requester IDs (CPU=0, DMA=1) SHALL live in a shared package/include used also by memory_bus integration.
REQ-031 Halt counter/timeout SHALL be one sub-module, halt_timer (clear, count, expired).
REQ-032 Arbiter SHALL sit between CPU/DMA and memory_bus; no combinational path from request to mem_* outputs.

Verification
REQ-033 cpu read 0x000010, bus returns 0x5A, no halt -> mem_bus_enable one cycle, cpu_data_out=0x5A, cpu_done one pulse 2 cycles after request sampled.
REQ-034 simultaneous cpu write 0x8001=0x33 and dma read 0x010000, both held -> cpu first, then dma; grant 0,1; each done once; then alternation continues.
REQ-035 dma read 0x020000 with mem_bus_halt high 50 cycles -> stays ACCESS 51 cycles, dma_done after halt falls, timeout_error=0.
REQ-036 HALT_TIMEOUT=8, halt stuck high -> abort after 8 halted cycles, timeout_error=1, dma_done pulse, dma_data_out unchanged.
REQ-037 reset low during ACCESS -> next edge IDLE, all outputs reset values, no done pulse.
REQ-038 cpu_request dropped mid-ACCESS -> access completes, cpu_done pulses once.
